// File: rtl/l1d_sram_pkg.sv
// Shared defaults and types for the L1D SRAM request front-end.
package l1d_sram_pkg;

  localparam int L1D_DATA_W    = 8;
  localparam int L1D_ADDR_W    = 8;
  localparam int L1D_RSP_DEPTH = 2;
  localparam int RSP_PTR_W     = $clog2(L1D_RSP_DEPTH);

  typedef struct packed {
    logic                  wr;
    logic [L1D_ADDR_W-1:0] addr;
    logic [L1D_DATA_W-1:0] be;
    logic [L1D_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; head word is presented on dout.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front-end for the L1D single-port SRAM: combinational issue,
// credit-checked read responses buffered in a small FIFO.
module sram_req_ctrl
  import l1d_sram_pkg::*;
#(
  parameter int DATA_WIDTH = L1D_DATA_W,
  parameter int ADDR_WIDTH = L1D_ADDR_W,
  parameter int RSP_DEPTH  = L1D_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_en,
  output logic                  sram_wr,
  output logic [DATA_WIDTH-1:0] sram_be,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  idle
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  logic             inflight;
  logic             rd_issue;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;

  // A pop this cycle returns its credit immediately, so back-to-back reads
  // keep flowing with only two entries.
  assign credit_used = (CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(fifo_pop);
  assign req_rdy     = rst_n & (req_wr | (credit_used < (CNT_W+1)'(RSP_DEPTH)));

  assign sram_en    = req_vld & req_rdy;
  assign sram_wr    = sram_en & req_wr;
  assign sram_be    = sram_wr ? req_be : '0;
  assign sram_addr  = req_addr;
  assign sram_wdata = req_wdata;
  assign rd_issue   = sram_en & ~req_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= rd_issue;
  end

  assign fifo_push = inflight;
  assign fifo_pop  = rsp_vld & rsp_rdy;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sram_rdata),
    .dout  (rsp_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_vld = ~fifo_empty;
  assign idle    = ~inflight & fifo_empty;

  a_push_after_read: assert property (@(posedge clk) disable iff (!rst_n)
                                      fifo_push |-> $past(rd_issue));
  a_push_has_room:   assert property (@(posedge clk) disable iff (!rst_n)
                                      fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural single-port SRAM model.
module tb_sram_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_vld, req_rdy, req_wr;
  logic [7:0] req_addr, req_be, req_wdata;
  logic       rsp_vld, rsp_rdy;
  logic [7:0] rsp_rdata;
  logic       sram_en, sram_wr;
  logic [7:0] sram_be, sram_addr, sram_wdata, sram_rdata;
  logic       idle;

  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_errs   = 0;

  always #5 clk = ~clk;

  sram_req_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_rdata  (rsp_rdata),
    .sram_en    (sram_en),
    .sram_wr    (sram_wr),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .idle       (idle)
  );

  // SRAM macro model: bit-masked write at the edge, read data valid next cycle.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wr) mem[sram_addr] <= (mem[sram_addr] & ~sram_be) | (sram_wdata & sram_be);
      else         sram_rdata <= mem[sram_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic [7:0] be);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    #1;
    check_val("wr_rdy",   req_rdy, 1);
    check_val("wr_en",    sram_en, 1);
    check_val("wr_wr",    sram_wr, 1);
    check_val("wr_be",    sram_be, be);
    check_val("wr_addr",  sram_addr, a);
    check_val("wr_wdata", sram_wdata, d);
    step();
    req_vld = 1'b0;
  endtask

  task automatic do_read_check(input logic [7:0] a, input logic [7:0] exp);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a; req_be = 8'hFF;
    #1;
    check_val("rd_rdy",  req_rdy, 1);
    check_val("rd_en",   sram_en, 1);
    check_val("rd_wr",   sram_wr, 0);
    check_val("rd_be",   sram_be, 0);
    check_val("rd_addr", sram_addr, a);
    step();
    req_vld = 1'b0;
    #1;
    check_val("rd_lat1_vld", rsp_vld, 0);
    step();
    check_val("rd_lat2_vld", rsp_vld, 1);
    check_val("rd_data",     rsp_rdata, exp);
    step();
  endtask

  initial begin
    logic [7:0] exp_d;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    sram_rdata = 8'h00;

    rst_n = 1'b0; req_vld = 1'b1; req_wr = 1'b1; req_addr = 8'h00;
    req_be = 8'hFF; req_wdata = 8'h00; rsp_rdy = 1'b1;
    step(); step();
    check_val("rst_rsp_vld", rsp_vld, 0);
    check_val("rst_idle",    idle, 1);
    check_val("rst_req_rdy", req_rdy, 0);
    check_val("rst_sram_en", sram_en, 0);
    req_vld = 1'b0;
    rst_n = 1'b1;
    step();
    check_val("post_rst_idle", idle, 1);

    // full write then read
    do_write(8'h10, 8'hA5, 8'hFF);
    do_read_check(8'h10, 8'hA5);

    // partial write: (A5 & F0) | (3C & 0F) = AC
    do_write(8'h10, 8'h3C, 8'h0F);
    do_read_check(8'h10, 8'hAC);

    // back-to-back reads
    for (int i = 1; i <= 4; i++) begin
      exp_d = 8'(i * 8'h11);
      do_write(8'(i), exp_d, 8'hFF);
    end
    rsp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'(i + 1);
      end else begin
        req_vld = 1'b0;
      end
      #1;
      if (i < 4) check_val("b2b_rdy", req_rdy, 1);
      if (i >= 2) begin
        exp_d = 8'((i - 1) * 8'h11);
        check_val("b2b_vld",  rsp_vld, 1);
        check_val("b2b_data", rsp_rdata, exp_d);
      end else begin
        check_val("b2b_vld_early", rsp_vld, 0);
      end
      step();
    end
    check_val("b2b_drained", idle, 1);

    // backpressure: two reads fill the credits, the third stalls
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h01; #1;
    check_val("bp_rd1_rdy", req_rdy, 1);
    step();
    req_addr = 8'h02; #1;
    check_val("bp_rd2_rdy", req_rdy, 1);
    step();
    req_addr = 8'h03; #1;
    check_val("bp_rd3_stall", req_rdy, 0);
    check_val("bp_rd3_en",    sram_en, 0);
    step();
    #1;
    check_val("bp_rd3_stall2", req_rdy, 0);
    check_val("bp_hold_vld",   rsp_vld, 1);
    check_val("bp_hold_data",  rsp_rdata, 8'h11);
    check_val("bp_not_idle",   idle, 0);
    step();
    check_val("bp_stable_data", rsp_rdata, 8'h11);
    req_wr = 1'b1; req_addr = 8'h30; req_wdata = 8'h77; req_be = 8'hFF; #1;
    check_val("bp_wr_rdy", req_rdy, 1);
    check_val("bp_wr_en",  sram_en, 1);
    step();
    req_wr = 1'b0; req_addr = 8'h03; rsp_rdy = 1'b1; #1;
    check_val("bp_pop1_vld",  rsp_vld, 1);
    check_val("bp_pop1_data", rsp_rdata, 8'h11);
    check_val("bp_rd3_rdy",   req_rdy, 1);
    step();
    req_vld = 1'b0; #1;
    check_val("bp_pop2_vld",  rsp_vld, 1);
    check_val("bp_pop2_data", rsp_rdata, 8'h22);
    step();
    check_val("bp_pop3_vld",  rsp_vld, 1);
    check_val("bp_pop3_data", rsp_rdata, 8'h33);
    step();
    check_val("bp_empty_vld", rsp_vld, 0);
    check_val("bp_idle",      idle, 1);
    do_read_check(8'h30, 8'h77);

    // write then read same address next cycle
    do_write(8'h20, 8'h55, 8'hFF);
    do_read_check(8'h20, 8'h55);

    // reset with one read in flight and one response held
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h01;
    step();
    req_addr = 8'h02;
    step();
    req_vld = 1'b0; #1;
    check_val("mid_rst_held_vld", rsp_vld, 1);
    check_val("mid_rst_busy",     idle, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; #1;
    check_val("mid_rst_vld",  rsp_vld, 0);
    check_val("mid_rst_idle", idle, 1);
    rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("mid_rst_no_stale", rsp_vld, 0);
    end
    check_val("final_idle", idle, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
